// File: rtl/serial_bit_feeder.sv
// serial_bit_feeder: parallel-to-serial front end for serial sequence detectors.
// Accepts a WIDTH-bit word over valid/ready and shifts it out on x, one bit per clock.
// Optional feature macro: SERIAL_FEEDER_PARITY_EN appends an even-parity bit after each word.
module serial_bit_feeder #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             x,
    output logic             x_valid,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

`ifdef SERIAL_FEEDER_PARITY_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;
`else
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;
`endif

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_shift;
    logic [WIDTH-1:0]   w_shift_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               r_x;
    logic               w_x_nxt;
    logic               r_x_valid;
    logic               w_x_valid_nxt;
    logic               r_busy;
    logic               w_busy_nxt;
    logic               r_done;
    logic               w_done_nxt;
`ifdef SERIAL_FEEDER_PARITY_EN
    logic               r_par;
    logic               w_par_nxt;
`endif

    logic               w_last_bit;
    logic               w_din_ready;
    logic               w_xfer;
    logic [WIDTH-1:0]   w_shift_step;
    logic               w_step_bit;
    logic               w_first_bit;

    // r_cnt holds the 1-based index of the bit currently on x
    assign w_last_bit = (r_state == SHIFT) && (r_cnt == CNT_W'(WIDTH));

    // Ready when idle, or when the current word's final serial cycle is on x
`ifdef SERIAL_FEEDER_PARITY_EN
    assign w_din_ready = (r_state == IDLE) || (r_state == PARITY);
`else
    assign w_din_ready = (r_state == IDLE) || w_last_bit;
`endif

    assign w_xfer = din_valid && w_din_ready;

    // Shift-register step and the bit that becomes visible after it
    assign w_shift_step = MSB_FIRST ? {r_shift[WIDTH-2:0], 1'b0} : {1'b0, r_shift[WIDTH-1:1]};
    assign w_step_bit   = MSB_FIRST ? w_shift_step[WIDTH-1] : w_shift_step[0];
    assign w_first_bit  = MSB_FIRST ? din[WIDTH-1] : din[0];

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and next-output decode; a transfer always wins and reloads the word
    always_comb begin
        w_state_nxt   = r_state;
        w_shift_nxt   = r_shift;
        w_cnt_nxt     = r_cnt;
        w_x_nxt       = 1'b0;
        w_x_valid_nxt = 1'b0;
        w_busy_nxt    = 1'b0;
        w_done_nxt    = 1'b0;
`ifdef SERIAL_FEEDER_PARITY_EN
        w_par_nxt     = r_par;
`endif
        if (w_xfer) begin
            w_state_nxt   = SHIFT;
            w_shift_nxt   = din;
            w_cnt_nxt     = CNT_W'(1);
            w_x_nxt       = w_first_bit;
            w_x_valid_nxt = 1'b1;
            w_busy_nxt    = 1'b1;
`ifdef SERIAL_FEEDER_PARITY_EN
            w_par_nxt     = ^din;
`endif
        end else begin
            case (r_state)
                SHIFT: begin
                    if (!w_last_bit) begin
                        w_shift_nxt   = w_shift_step;
                        w_cnt_nxt     = r_cnt + CNT_W'(1);
                        w_x_nxt       = w_step_bit;
                        w_x_valid_nxt = 1'b1;
                        w_busy_nxt    = 1'b1;
`ifndef SERIAL_FEEDER_PARITY_EN
                        w_done_nxt    = (r_cnt == CNT_W'(WIDTH - 1));
`endif
                    end else begin
`ifdef SERIAL_FEEDER_PARITY_EN
                        w_state_nxt   = PARITY;
                        w_x_nxt       = r_par;
                        w_x_valid_nxt = 1'b1;
                        w_busy_nxt    = 1'b1;
                        w_done_nxt    = 1'b1;
`else
                        w_state_nxt   = IDLE;
                        w_shift_nxt   = '0;
                        w_cnt_nxt     = '0;
`endif
                    end
                end
`ifdef SERIAL_FEEDER_PARITY_EN
                PARITY: begin
                    w_state_nxt = IDLE;
                    w_shift_nxt = '0;
                    w_cnt_nxt   = '0;
                end
`endif
                default: begin
                end
            endcase
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift   <= '0;
            r_cnt     <= '0;
            r_x       <= 1'b0;
            r_x_valid <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
`ifdef SERIAL_FEEDER_PARITY_EN
            r_par     <= 1'b0;
`endif
        end else begin
            r_shift   <= w_shift_nxt;
            r_cnt     <= w_cnt_nxt;
            r_x       <= w_x_nxt;
            r_x_valid <= w_x_valid_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
`ifdef SERIAL_FEEDER_PARITY_EN
            r_par     <= w_par_nxt;
`endif
        end
    end

    assign din_ready = w_din_ready;
    assign x         = r_x;
    assign x_valid   = r_x_valid;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_serial_bit_feeder.sv
// tb_serial_bit_feeder: scoreboard bench for serial_bit_feeder (MSB-first and LSB-first instances).
module tb_serial_bit_feeder;

    localparam int unsigned WIDTH = 8;
`ifdef SERIAL_FEEDER_PARITY_EN
    localparam int P       = WIDTH + 1;
    localparam int DET_EXP = 2;
`else
    localparam int P       = WIDTH;
    localparam int DET_EXP = 3;
`endif

    typedef struct packed {
        logic x;
        logic done;
    } exp_t;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] a_din, b_din;
    logic             a_din_valid, b_din_valid;
    logic             a_din_ready, b_din_ready;
    logic             a_x, b_x;
    logic             a_x_valid, b_x_valid;
    logic             a_busy, b_busy;
    logic             a_done, b_done;

    exp_t q_a[$];
    exp_t q_b[$];
    int   n_cmp = 0;
    int   n_err = 0;

    serial_bit_feeder #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) u_dut_msb (
        .clk(clk), .rst(rst), .din(a_din), .din_valid(a_din_valid), .din_ready(a_din_ready),
        .x(a_x), .x_valid(a_x_valid), .busy(a_busy), .done(a_done)
    );

    serial_bit_feeder #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) u_dut_lsb (
        .clk(clk), .rst(rst), .din(b_din), .din_valid(b_din_valid), .din_ready(b_din_ready),
        .x(b_x), .x_valid(b_x_valid), .busy(b_busy), .done(b_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected serial stream for one word, pushed at the accepting edge
    function automatic void push_word(input logic [WIDTH-1:0] w, input bit msb, input bit to_b);
        exp_t e;
        for (int i = 0; i < int'(WIDTH); i++) begin
            e.x = msb ? w[WIDTH-1-i] : w[i];
`ifdef SERIAL_FEEDER_PARITY_EN
            e.done = 1'b0;
`else
            e.done = (i == int'(WIDTH) - 1);
`endif
            if (to_b) q_b.push_back(e); else q_a.push_back(e);
        end
`ifdef SERIAL_FEEDER_PARITY_EN
        e.x    = ^w;
        e.done = 1'b1;
        if (to_b) q_b.push_back(e); else q_a.push_back(e);
`endif
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        a_din = 8'hFF; a_din_valid = 1'b1;
        b_din = 8'hFF; b_din_valid = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({a_x, a_x_valid, a_busy, a_done, a_din_ready} !== 5'b00001) begin
            n_err++;
            $display("FAIL reset_a: got x/xv/busy/done/rdy=%b want 00001",
                     {a_x, a_x_valid, a_busy, a_done, a_din_ready});
        end
        n_cmp++;
        if ({b_x, b_x_valid, b_busy, b_done, b_din_ready} !== 5'b00001) begin
            n_err++;
            $display("FAIL reset_b: got x/xv/busy/done/rdy=%b want 00001",
                     {b_x, b_x_valid, b_busy, b_done, b_din_ready});
        end
        rst = 1'b0; a_din_valid = 1'b0; b_din_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({a_x_valid, a_busy, b_x_valid, b_busy} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_no_xfer: got xv/busy a,b=%b want 0000",
                     {a_x_valid, a_busy, b_x_valid, b_busy});
        end
    endtask

    task automatic test_single();
        exp_t e;
        int   nvalid = 0;
        @(posedge clk); #1;
        a_din = 8'hA5; a_din_valid = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({a_din_ready, a_x_valid} !== 2'b10) begin
            n_err++;
            $display("FAIL single_pre: got rdy/xv=%b want 10", {a_din_ready, a_x_valid});
        end
        @(posedge clk);
        push_word(8'hA5, 1'b1, 1'b0);
        #1 a_din_valid = 1'b0;
        for (int c = 0; c < P + 2; c++) begin
            @(negedge clk);
            n_cmp++;
            if (a_x_valid) begin
                nvalid++;
                if (q_a.size() == 0) begin
                    n_err++;
                    $display("FAIL single_extra: unexpected valid bit x=%0b", a_x);
                end else begin
                    e = q_a.pop_front();
                    if ({a_x, a_done, a_din_ready, a_busy} !== {e.x, e.done, e.done, 1'b1}) begin
                        n_err++;
                        $display("FAIL single_bit%0d: got x/done/rdy/busy=%b want %b",
                                 c, {a_x, a_done, a_din_ready, a_busy}, {e.x, e.done, e.done, 1'b1});
                    end
                end
            end else if ({a_x, a_done, a_busy, a_din_ready} !== 4'b0001) begin
                n_err++;
                $display("FAIL single_idle%0d: got x/done/busy/rdy=%b want 0001",
                         c, {a_x, a_done, a_busy, a_din_ready});
            end
        end
        n_cmp++;
        if (nvalid != P || q_a.size() != 0) begin
            n_err++;
            $display("FAIL single_count: got %0d valid bits (%0d left) want %0d", nvalid, q_a.size(), P);
        end
        q_a.delete();
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] words [2];
        exp_t       e;
        int         sent = 0, nvalid = 0, ndone = 0, det = 0;
        logic [3:0] sh = '0;
        bit         started = 1'b0, rdy, finished = 1'b0;
        words[0] = 8'h0A;
        words[1] = 8'hA0;
        @(posedge clk); #1;
        a_din = words[0]; a_din_valid = 1'b1;
        for (int c = 0; c < 40 && !finished; c++) begin
            @(negedge clk);
            rdy = a_din_ready;
            if (a_x_valid) begin
                started = 1'b1;
                nvalid++;
                sh = {sh[2:0], a_x};
                if (sh == 4'b1010) det++;
                if (a_done) ndone++;
                n_cmp++;
                if (q_a.size() == 0) begin
                    n_err++;
                    $display("FAIL b2b_extra: unexpected valid bit x=%0b", a_x);
                end else begin
                    e = q_a.pop_front();
                    if ({a_x, a_done, a_din_ready} !== {e.x, e.done, e.done}) begin
                        n_err++;
                        $display("FAIL b2b_bit%0d: got x/done/rdy=%b want %b",
                                 nvalid, {a_x, a_done, a_din_ready}, {e.x, e.done, e.done});
                    end
                end
            end else if (started) begin
                if (sent == 2 && q_a.size() == 0) begin
                    finished = 1'b1;
                end else begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL b2b_gap: x_valid=0 after %0d bits, want continuous", nvalid);
                end
            end
            if (!finished) begin
                @(posedge clk);
                if (rdy && a_din_valid) begin
                    push_word(words[sent], 1'b1, 1'b0);
                    sent++;
                    #1;
                    if (sent < 2) a_din = words[sent];
                    else a_din_valid = 1'b0;
                end
            end
        end
        a_din_valid = 1'b0;
        n_cmp++;
        if (!finished || nvalid != 2 * P || ndone != 2) begin
            n_err++;
            $display("FAIL b2b_stream: got %0d bits %0d dones finished=%0b want %0d bits 2 dones",
                     nvalid, ndone, finished, 2 * P);
        end
        n_cmp++;
        if (det != DET_EXP) begin
            n_err++;
            $display("FAIL b2b_detect: got %0d 1010 matches want %0d", det, DET_EXP);
        end
        q_a.delete();
    endtask

    task automatic test_lsb();
        exp_t e;
        int   nvalid = 0;
        @(posedge clk); #1;
        b_din = 8'h01; b_din_valid = 1'b1;
        @(posedge clk);
        push_word(8'h01, 1'b0, 1'b1);
        #1 b_din_valid = 1'b0;
        for (int c = 0; c < P + 2; c++) begin
            @(negedge clk);
            if (c == 2) b_din = 8'h55;
            n_cmp++;
            if (b_x_valid) begin
                nvalid++;
                if (q_b.size() == 0) begin
                    n_err++;
                    $display("FAIL lsb_extra: unexpected valid bit x=%0b", b_x);
                end else begin
                    e = q_b.pop_front();
                    if ({b_x, b_done, b_din_ready, b_busy} !== {e.x, e.done, e.done, 1'b1}) begin
                        n_err++;
                        $display("FAIL lsb_bit%0d: got x/done/rdy/busy=%b want %b",
                                 c, {b_x, b_done, b_din_ready, b_busy}, {e.x, e.done, e.done, 1'b1});
                    end
                end
            end else if ({b_x, b_done, b_busy, b_din_ready} !== 4'b0001) begin
                n_err++;
                $display("FAIL lsb_idle%0d: got x/done/busy/rdy=%b want 0001",
                         c, {b_x, b_done, b_busy, b_din_ready});
            end
        end
        n_cmp++;
        if (nvalid != P || q_b.size() != 0) begin
            n_err++;
            $display("FAIL lsb_count: got %0d valid bits (%0d left) want %0d", nvalid, q_b.size(), P);
        end
        q_b.delete();
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int   nvalid = 0;
        @(posedge clk); #1;
        a_din = 8'hC3; a_din_valid = 1'b1;
        @(posedge clk);
        push_word(8'hC3, 1'b1, 1'b0);
        #1 a_din_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            e = q_a.pop_front();
            n_cmp++;
            if ({a_x_valid, a_x, a_done} !== {1'b1, e.x, 1'b0}) begin
                n_err++;
                $display("FAIL rstmid_bit%0d: got xv/x/done=%b want %b", i, {a_x_valid, a_x, a_done}, {1'b1, e.x, 1'b0});
            end
            if (i == 3) begin
                @(posedge clk); #1;
                rst = 1'b1;
            end
        end
        @(posedge clk); #1;
        rst = 1'b0;
        q_a.delete();
        a_din = 8'hFF; a_din_valid = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({a_x_valid, a_x, a_busy, a_done, a_din_ready} !== 5'b00001) begin
            n_err++;
            $display("FAIL rstmid_after: got xv/x/busy/done/rdy=%b want 00001",
                     {a_x_valid, a_x, a_busy, a_done, a_din_ready});
        end
        @(posedge clk);
        push_word(8'hFF, 1'b1, 1'b0);
        #1 a_din_valid = 1'b0;
        for (int c = 0; c < P + 2; c++) begin
            @(negedge clk);
            if (a_x_valid) begin
                nvalid++;
                n_cmp++;
                if (q_a.size() == 0) begin
                    n_err++;
                    $display("FAIL rstmid_extra: unexpected valid bit x=%0b", a_x);
                end else begin
                    e = q_a.pop_front();
                    if ({a_x, a_done} !== {e.x, e.done}) begin
                        n_err++;
                        $display("FAIL rstmid_ff%0d: got x/done=%b want %b", c, {a_x, a_done}, {e.x, e.done});
                    end
                end
            end
        end
        n_cmp++;
        if (nvalid != P || q_a.size() != 0) begin
            n_err++;
            $display("FAIL rstmid_count: got %0d valid bits want %0d", nvalid, P);
        end
        q_a.delete();
    endtask

`ifdef SERIAL_FEEDER_PARITY_EN
    task automatic test_parity();
        exp_t e;
        @(posedge clk); #1;
        a_din = 8'h07; a_din_valid = 1'b1;
        @(posedge clk);
        push_word(8'h07, 1'b1, 1'b0);
        #1 a_din_valid = 1'b0;
        for (int c = 1; c <= P; c++) begin
            @(negedge clk);
            e = q_a.pop_front();
            n_cmp++;
            if ({a_x_valid, a_x, a_done} !== {1'b1, e.x, e.done}) begin
                n_err++;
                $display("FAIL parity_bit%0d: got xv/x/done=%b want %b", c, {a_x_valid, a_x, a_done}, {1'b1, e.x, e.done});
            end
            if (c == 8 || c == 9) begin
                n_cmp++;
                if (a_din_ready !== (c == 9)) begin
                    n_err++;
                    $display("FAIL parity_rdy%0d: got %0b want %0b", c, a_din_ready, (c == 9));
                end
            end
        end
        @(negedge clk);
        n_cmp++;
        if ({a_x_valid, a_busy} !== 2'b00) begin
            n_err++;
            $display("FAIL parity_idle: got xv/busy=%b want 00", {a_x_valid, a_busy});
        end
        q_a.delete();
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_lsb();
        test_reset_mid();
`ifdef SERIAL_FEEDER_PARITY_EN
        test_parity();
`endif
        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
